noc_switch_alloc: RTL and testbench

- Per-output switch allocator and credit tracker for the 5-port NoC router (north, south, east, west, local).
- Shares each output port among the 5 input ports using round-robin.
- Holds a wormhole lock on an output from head flit to tail flit.
- Gates every grant on a per-output downstream credit counter, replenished by credit_en_*.
- Drives crossbar selects and grant_access_* to the datapath.

---
 rtl/noc_switch_alloc.sv | 139 +++++++++++++
 tb/tb_noc_switch_alloc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/noc_switch_alloc.sv
// Switch allocator and credit tracker for a 5-port NoC router: one round-robin arbiter
// per output, with a wormhole lock from head to tail and downstream credit gating.
module noc_switch_alloc #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  req_valid_i,
  input  logic [4:0]  req_tail_i,
  input  logic [2:0]  req_port_addr1_i,
  input  logic [2:0]  req_port_addr2_i,
  input  logic [2:0]  req_port_addr3_i,
  input  logic [2:0]  req_port_addr4_i,
  input  logic [2:0]  req_port_addr5_i,
  input  logic        credit_en_north,
  input  logic        credit_en_south,
  input  logic        credit_en_east,
  input  logic        credit_en_west,
  input  logic        credit_en_local,
  output logic        grant_access_north,
  output logic        grant_access_south,
  output logic        grant_access_east,
  output logic        grant_access_west,
  output logic        grant_access_local,
  output logic [4:0]  in_grant_o,
  output logic [14:0] xbar_sel_o,
  output logic        credit_err_o
);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e           state_q [5];
  state_e           state_d [5];
  logic [2:0]       owner_q [5];
  logic [2:0]       owner_d [5];
  logic [2:0]       rr_q    [5];
  logic [2:0]       rr_d    [5];
  logic [CNT_W-1:0] cred_q  [5];
  logic [CNT_W-1:0] cred_d  [5];
  logic             err_q, err_d;

  logic [2:0] addr [5];
  logic [4:0] cred_en;
  logic [4:0] out_gnt;
  logic [2:0] win [5];
  logic [3:0] idx;
  logic       found;

  always_comb begin
    addr[0] = req_port_addr1_i;
    addr[1] = req_port_addr2_i;
    addr[2] = req_port_addr3_i;
    addr[3] = req_port_addr4_i;
    addr[4] = req_port_addr5_i;
    cred_en = {credit_en_local, credit_en_west, credit_en_east, credit_en_south,
               credit_en_north};
    err_d      = err_q;
    in_grant_o = '0;
    xbar_sel_o = '1;
    idx        = '0;
    found      = 1'b0;
    for (int o = 0; o < 5; o++) begin
      out_gnt[o] = 1'b0;
      win[o]     = 3'd7;
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      cred_d[o]  = cred_q[o];
      found      = 1'b0;
      if (rst_n && cred_q[o] != '0) begin
        if (state_q[o] == StLocked) begin
          if (req_valid_i[owner_q[o]] && addr[owner_q[o]] == 3'(o)) begin
            out_gnt[o] = 1'b1;
            win[o]     = owner_q[o];
          end
        end else begin
          // Cyclic search starting at the round-robin pointer.
          for (int k = 0; k < 5; k++) begin
            idx = {1'b0, rr_q[o]} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!found && req_valid_i[idx[2:0]] && addr[idx[2:0]] == 3'(o)) begin
              found      = 1'b1;
              out_gnt[o] = 1'b1;
              win[o]     = idx[2:0];
            end
          end
        end
      end
      if (out_gnt[o]) begin
        in_grant_o[win[o]]  = 1'b1;
        xbar_sel_o[o*3 +: 3] = win[o];
        rr_d[o] = (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
        if (req_tail_i[win[o]]) begin
          state_d[o] = StUnlocked;
        end else begin
          state_d[o] = StLocked;
          owner_d[o] = win[o];
        end
      end
      unique case ({out_gnt[o], cred_en[o]})
        2'b10: cred_d[o] = cred_q[o] - 1'b1;
        2'b01: begin
          if (cred_q[o] == CNT_W'(BUF_DEPTH)) err_d = 1'b1;
          else cred_d[o] = cred_q[o] + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant_access_north = out_gnt[0];
  assign grant_access_south = out_gnt[1];
  assign grant_access_east  = out_gnt[2];
  assign grant_access_west  = out_gnt[3];
  assign grant_access_local = out_gnt[4];
  assign credit_err_o       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < 5; o++) begin
        state_q[o] <= StUnlocked;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
        cred_q[o]  <= CNT_W'(BUF_DEPTH);
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        cred_q[o]  <= cred_d[o];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed scoreboard bench for noc_switch_alloc: expected per-cycle outputs are queued by the
// driver and compared on the falling edge.
module tb_noc_switch_alloc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  vld, tl, cen;
  logic [2:0]  a [5];
  logic        g_n, g_s, g_e, g_w, g_l;
  logic [4:0]  in_grant;
  logic [14:0] xsel;
  logic        err;

  typedef struct packed {
    logic [4:0]  gnt;
    logic [4:0]  acc;
    logic [14:0] sel;
    logic        err;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    total = 0;
  int    bad   = 0;

  localparam logic [14:0] Idle = 15'h7fff;

  always #5 clk = ~clk;

  noc_switch_alloc #(.BUF_DEPTH(4), .CNT_W(3)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_i        (vld),
    .req_tail_i         (tl),
    .req_port_addr1_i   (a[0]),
    .req_port_addr2_i   (a[1]),
    .req_port_addr3_i   (a[2]),
    .req_port_addr4_i   (a[3]),
    .req_port_addr5_i   (a[4]),
    .credit_en_north    (cen[0]),
    .credit_en_south    (cen[1]),
    .credit_en_east     (cen[2]),
    .credit_en_west     (cen[3]),
    .credit_en_local    (cen[4]),
    .grant_access_north (g_n),
    .grant_access_south (g_s),
    .grant_access_east  (g_e),
    .grant_access_west  (g_w),
    .grant_access_local (g_l),
    .in_grant_o         (in_grant),
    .xbar_sel_o         (xsel),
    .credit_err_o       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] sel(input int n, input int s, input int e, input int w,
                                      input int l);
    return {3'(l), 3'(w), 3'(e), 3'(s), 3'(n)};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".in_grant"}, 32'(in_grant), 32'(e.gnt));
      check({t, ".access"}, 32'({g_l, g_w, g_e, g_s, g_n}), 32'(e.acc));
      check({t, ".xsel"}, 32'(xsel), 32'(e.sel));
      check({t, ".err"}, 32'(err), 32'(e.err));
    end
  end

  // Queue this cycle's expectation, then advance one clock.
  task automatic cyc(input string tag, input logic [4:0] g, input logic [4:0] acc,
                     input logic [14:0] s, input logic e);
    exp_t x;
    x.gnt = g; x.acc = acc; x.sel = s; x.err = e;
    exp_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    vld = '0; tl = '0; cen = '0;
    for (int i = 0; i < 5; i++) a[i] = 3'd0;
    @(posedge clk);
    #1;
    // Requests during reset must not be granted.
    vld = 5'b00001; tl = 5'b00001; a[0] = 3'd2;
    cyc("reset", 5'b0, 5'b0, Idle, 1'b0);
    rst_n = 1'b1;

    // Single head+tail flit to E; invalid address 6 on input 5 alongside.
    vld = 5'b10001; a[4] = 3'd6;
    cyc("single_e", 5'b00001, 5'b00100, sel(7, 7, 0, 7, 7), 1'b0);
    vld = '0;

    // Three tail requesters on N, credits returned each cycle: fair 1,2,3 rotation twice.
    a[0] = 3'd0; a[1] = 3'd0; a[2] = 3'd0; tl = 5'b11111; vld = 5'b00111; cen = 5'b00001;
    for (int k = 0; k < 6; k++)
      cyc("rr_n", 5'(1 << (k % 3)), 5'b00001, sel(k % 3, 7, 7, 7, 7), 1'b0);
    vld = '0; cen = '0;

    // 3-flit packet from input 4 to L holds the lock against input 5.
    a[3] = 3'd4; a[4] = 3'd4; tl = 5'b10000; vld = 5'b11000;
    cyc("lock_l1", 5'b01000, 5'b10000, sel(7, 7, 7, 7, 3), 1'b0);
    cyc("lock_l2", 5'b01000, 5'b10000, sel(7, 7, 7, 7, 3), 1'b0);
    tl = 5'b11000;
    cyc("lock_l3", 5'b01000, 5'b10000, sel(7, 7, 7, 7, 3), 1'b0);
    vld = 5'b10000;
    cyc("after_tail", 5'b10000, 5'b10000, sel(7, 7, 7, 7, 4), 1'b0);
    vld = '0;

    // Drain S credits, stall, then one returned credit allows exactly one grant.
    a[0] = 3'd1; tl = 5'b00001; vld = 5'b00001;
    for (int k = 0; k < 4; k++) cyc("s_drain", 5'b00001, 5'b00010, sel(7, 0, 7, 7, 7), 1'b0);
    cyc("s_stall", 5'b0, 5'b0, Idle, 1'b0);
    cen = 5'b00010;
    cyc("s_cred_in", 5'b0, 5'b0, Idle, 1'b0);
    cen = '0;
    cyc("s_regrant", 5'b00001, 5'b00010, sel(7, 0, 7, 7, 7), 1'b0);
    cyc("s_stall2", 5'b0, 5'b0, Idle, 1'b0);
    vld = '0;

    // W: grant plus credit at count 2 keeps 2, so exactly two more grants follow.
    a[1] = 3'd3; tl = 5'b00010; vld = 5'b00010;
    cyc("w_g1", 5'b00010, 5'b01000, sel(7, 7, 7, 1, 7), 1'b0);
    cyc("w_g2", 5'b00010, 5'b01000, sel(7, 7, 7, 1, 7), 1'b0);
    cen = 5'b01000;
    cyc("w_g_cred", 5'b00010, 5'b01000, sel(7, 7, 7, 1, 7), 1'b0);
    cen = '0;
    cyc("w_g4", 5'b00010, 5'b01000, sel(7, 7, 7, 1, 7), 1'b0);
    cyc("w_g5", 5'b00010, 5'b01000, sel(7, 7, 7, 1, 7), 1'b0);
    cyc("w_stall", 5'b0, 5'b0, Idle, 1'b0);
    vld = '0; cen = 5'b01000;
    for (int k = 0; k < 4; k++) cyc("w_refill", 5'b0, 5'b0, Idle, 1'b0);
    cyc("w_overflow", 5'b0, 5'b0, Idle, 1'b0);
    cen = '0;
    cyc("err_set", 5'b0, 5'b0, Idle, 1'b1);
    cyc("err_sticky", 5'b0, 5'b0, Idle, 1'b1);

    // Lock N on input 1 (rr_ptr at 3), block input 2, then reset mid-packet.
    a[0] = 3'd0; tl = 5'b00000; vld = 5'b00001;
    cyc("n_head", 5'b00001, 5'b00001, sel(0, 7, 7, 7, 7), 1'b1);
    a[1] = 3'd0; tl = 5'b00010; vld = 5'b00010;
    cyc("n_locked", 5'b0, 5'b0, Idle, 1'b1);
    rst_n = 1'b0;
    cyc("mid_reset", 5'b0, 5'b0, Idle, 1'b0);
    rst_n = 1'b1;
    a[2] = 3'd1; a[4] = 3'd6; tl = 5'b11111; vld = 5'b10110;
    cyc("post_reset", 5'b00110, 5'b00011, sel(1, 2, 7, 7, 7), 1'b0);

    // All five outputs grant in the same cycle.
    for (int i = 0; i < 5; i++) a[i] = 3'(i);
    vld = 5'b11111;
    cyc("all_five", 5'b11111, 5'b11111, sel(0, 1, 2, 3, 4), 1'b0);
    vld = '0;
    cyc("idle", 5'b0, 5'b0, Idle, 1'b0);

    repeat (2) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
